sr_noc_collector: RTL

Receive-side NoC endpoint that reassembles incoming flits into the 68-bit memory packet format used by the memory controller: | unused[67] | data[66:35] | address[34:3] | instr[2:0] |. It sits between the router's ejection port and the memory controller's packet input. It counterparts the transmit-side splitter that serialises controller packets into flits. It holds one assembled packet, so the next packet can be assembled while the controller is busy.

---
 rtl/sr_noc_collector.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sr_noc_collector.sv
// Receive-side NoC endpoint: reassembles header + payload flits into the 68-bit
// memory packet and holds one finished packet for the memory controller.
module sr_noc_collector #(
   parameter int FLIT_WIDTH      = 32,
   parameter int NODE_COUNT      = 8,
   parameter int PACKET_ID_WIDTH = 5,
   parameter int NODE_W          = $clog2(NODE_COUNT)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [FLIT_WIDTH-1:0]      flitIn,
   input  logic                       flitHead,
   input  logic                       flitValid,
   output logic                       flitReady,
   output logic [67:0]                packetOut,
   output logic [NODE_W-1:0]          nodeStart,
   output logic [PACKET_ID_WIDTH-1:0] packetIdOut,
   output logic                       validOut,
   input  logic                       readyToReceive,
   output logic [7:0]                 dropCount
);

   localparam int PAYLOAD_FLITS = (68 + FLIT_WIDTH - 1) / FLIT_WIDTH;
   localparam int BUF_W         = PAYLOAD_FLITS * FLIT_WIDTH;
   localparam int CNT_W         = $clog2(PAYLOAD_FLITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_FLITS - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_FULL    = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [BUF_W-1:0]           buf_q, buf_d;
   logic [NODE_W-1:0]          asm_node_q, asm_node_d;
   logic [PACKET_ID_WIDTH-1:0] asm_id_q, asm_id_d;
   logic                       valid_q, valid_d;
   logic [67:0]                pkt_q, pkt_d;
   logic [NODE_W-1:0]          node_q, node_d;
   logic [PACKET_ID_WIDTH-1:0] id_q, id_d;
   logic [7:0]                 drop_q, drop_d;

   logic accept, slot_avail, load, drop_inc;

   assign flitReady  = (state_q != S_FULL);
   assign accept     = flitValid && flitReady;
   // Slot may be reloaded when empty or when it is handing off this very cycle.
   assign slot_avail = !valid_q || readyToReceive;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      asm_node_d = asm_node_q;
      asm_id_d   = asm_id_q;
      load       = 1'b0;
      drop_inc   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (flitHead) begin
                  asm_node_d = flitIn[NODE_W-1:0];
                  asm_id_d   = flitIn[NODE_W +: PACKET_ID_WIDTH];
                  cnt_d      = '0;
                  state_d    = S_PAYLOAD;
               end else begin
                  drop_inc = 1'b1;
               end
            end
         end
         S_PAYLOAD: begin
            if (accept) begin
               if (flitHead) begin
                  // A new header abandons whatever was partially collected.
                  drop_inc   = 1'b1;
                  asm_node_d = flitIn[NODE_W-1:0];
                  asm_id_d   = flitIn[NODE_W +: PACKET_ID_WIDTH];
                  cnt_d      = '0;
               end else begin
                  buf_d[int'(cnt_q)*FLIT_WIDTH +: FLIT_WIDTH] = flitIn;
                  if (cnt_q == LAST_CNT) begin
                     cnt_d = '0;
                     if (slot_avail) begin
                        load    = 1'b1;
                        state_d = S_IDLE;
                     end else begin
                        state_d = S_FULL;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end
         S_FULL: begin
            if (slot_avail) begin
               load    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      pkt_d   = pkt_q;
      node_d  = node_q;
      id_d    = id_q;
      drop_d  = drop_q;
      if (valid_q && readyToReceive) valid_d = 1'b0;
      if (load) begin
         valid_d = 1'b1;
         pkt_d   = {1'b0, buf_d[66:0]};
         node_d  = asm_node_d;
         id_d    = asm_id_d;
      end
      if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         buf_q      <= '0;
         asm_node_q <= '0;
         asm_id_q   <= '0;
         valid_q    <= 1'b0;
         pkt_q      <= '0;
         node_q     <= '0;
         id_q       <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         asm_node_q <= asm_node_d;
         asm_id_q   <= asm_id_d;
         valid_q    <= valid_d;
         pkt_q      <= pkt_d;
         node_q     <= node_d;
         id_q       <= id_d;
         drop_q     <= drop_d;
      end
   end

   assign validOut    = valid_q;
   assign packetOut   = pkt_q;
   assign nodeStart   = node_q;
   assign packetIdOut = id_q;
   assign dropCount   = drop_q;

endmodule
